// File: rtl/pipeline_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types for the pipeline hazard/sequencing controller.
// FSM states, scoreboard entry, register-zero and NOP constants.
package cpu_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  function automatic logic sb_hit(
    input sb_entry_t  e,
    input logic [4:0] r
  );
    return e.valid && (e.rd == r);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: ID-stage operands, WB redirect strobe and controls.
// master = pipeline side (drives ID/WB info), slave = pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  import cpu_ctrl_pkg::*;

  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_wr;
  logic [4:0]       id_rd;
  logic             id_is_branch;
  logic             pc_update;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             issue;
  logic             redirect_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_uses_rs, id_uses_rt,
    output id_wr, id_rd, id_is_branch,
    output pc_update,
    input  pc_hold, ifid_hold, ifid_flush,
    input  idex_bubble, issue,
    input  redirect_err, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_uses_rs, id_uses_rt,
    input  id_wr, id_rd, id_is_branch,
    input  pc_update,
    output pc_hold, ifid_hold, ifid_flush,
    output idex_bubble, issue,
    output redirect_err, stall_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB in-flight destination shift register.
// Ports: push/push_rd new EX entry, clr_exmem squash, rs/rt query, hazard.
module hazard_scoreboard
  import cpu_ctrl_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [4:0] push_rd,
  input  logic       clr_exmem,
  input  logic       uses_rs,
  input  logic [4:0] rs,
  input  logic       uses_rt,
  input  logic [4:0] rt,
  output logic       hazard
);

  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t ex_d, mem_d, wb_d;

  always_comb begin
    ex_d.valid = push && (push_rd != REG_ZERO);
    ex_d.rd    = push_rd;
    mem_d      = ex_q;
    wb_d       = mem_q;
    if (clr_exmem) begin
      ex_d.valid  = 1'b0;
      mem_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  logic rs_hit, rt_hit;

  // a write-before-read regfile lets the WB entry satisfy the read
  assign rs_hit = sb_hit(ex_q, rs) || sb_hit(mem_q, rs) ||
                  (!WB_BYPASS && sb_hit(wb_q, rs));
  assign rt_hit = sb_hit(ex_q, rt) || sb_hit(mem_q, rt) ||
                  (!WB_BYPASS && sb_hit(wb_q, rt));

  assign hazard = (uses_rs && (rs != REG_ZERO) && rs_hit) ||
                  (uses_rt && (rt != REG_ZERO) && rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: issue/stall/flush decisions for the 5-stage pipeline.
// Ports: clk, rst (sync, active-low), bus (pipeline_ctrl_if.slave).
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int BR_LAT    = 3,
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 16
) (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam int BW = $clog2(BR_LAT + 1);
  localparam logic [BW-1:0] BR_ONE  = BW'(1);
  localparam logic [BW-1:0] BR_INIT = BW'(BR_LAT);

  state_e           state_q, state_d;
  logic [BW-1:0]    br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             redirect_err_q, redirect_err_d;

  logic pc_hold, ifid_hold, ifid_flush;
  logic idex_bubble, issue, clr_exmem;
  logic hazard;

  hazard_scoreboard #(
    .WB_BYPASS (WB_BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .push      (issue && bus.id_wr),
    .push_rd   (bus.id_rd),
    .clr_exmem (clr_exmem),
    .uses_rs   (bus.id_uses_rs),
    .rs        (bus.id_rs),
    .uses_rt   (bus.id_uses_rt),
    .rt        (bus.id_rt),
    .hazard    (hazard)
  );

  // one-hot case selects encode the priority order explicitly
  logic run, live;
  logic sel_redir, sel_br, sel_idle, sel_stall, sel_go;

  assign run       = (state_q == RUN);
  assign live      = rst && run && !bus.pc_update;
  assign sel_redir = rst && run && bus.pc_update;
  assign sel_br    = rst && !run;
  assign sel_idle  = live && !bus.id_valid;
  assign sel_stall = live && bus.id_valid && hazard;
  assign sel_go    = live && bus.id_valid && !hazard;

  always_comb begin
    pc_hold        = 1'b0;
    ifid_hold      = 1'b0;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    issue          = 1'b0;
    clr_exmem      = 1'b0;
    state_d        = state_q;
    br_cnt_d       = br_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    redirect_err_d = redirect_err_q;
    unique case (1'b1)
      !rst: ;
      sel_redir: begin
        ifid_flush     = 1'b1;
        idex_bubble    = 1'b1;
        clr_exmem      = 1'b1;
        redirect_err_d = 1'b1;
      end
      sel_br: begin
        idex_bubble = 1'b1;
        br_cnt_d    = br_cnt_q - BR_ONE;
        if (br_cnt_q > BR_ONE) begin
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
          if (bus.pc_update) redirect_err_d = 1'b1;
        end else begin
          // branch in WB: fetch resumes at pc_new or branch+4
          ifid_flush = bus.pc_update;
          state_d    = RUN;
        end
      end
      sel_idle: idex_bubble = 1'b1;
      sel_stall: begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      end
      sel_go: begin
        issue = 1'b1;
        if (bus.id_is_branch) begin
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
          state_d    = BR_WAIT;
          br_cnt_d   = BR_INIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      br_cnt_q       <= '0;
      stall_cnt_q    <= '0;
      redirect_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      br_cnt_q       <= br_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_err_q <= redirect_err_d;
    end
  end

  assign bus.pc_hold      = pc_hold;
  assign bus.ifid_hold    = ifid_hold;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.issue        = issue;
  assign bus.redirect_err = redirect_err_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage CPU pipeline (fetch/decode/alu/v_memory/write).
- Decides each cycle whether the instruction in ID issues to EX, or stalls with a bubble inserted.
- Flushes wrong-path fetches around control transfers; control transfers resolve in WB via pc_update.
- No forwarding: dependencies are resolved by stalling against a 3-entry in-flight destination scoreboard (EX/MEM/WB).

Parameters:
- BR_LAT, 3, cycles from branch issue until the branch is in WB (EX, MEM, WB).
- WB_BYPASS, 0, 1 = register file is write-before-read, so the WB entry is excluded from the hazard check.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID holds a real instruction (not a NOP/bubble).
- id_rs  in  5  source register A.
- id_rt  in  5  source register B.
- id_uses_rs  in  1  instruction reads id_rs.
- id_uses_rt  in  1  instruction reads id_rt.
- id_wr  in  1  instruction writes a register.
- id_rd  in  5  destination register (Ri).
- id_is_branch  in  1  control-transfer instruction.
- pc_update  in  1  WB redirect strobe (from write stage).
- pc_hold  out  1  hold PC this cycle.
- ifid_hold  out  1  IF/ID register keeps its value.
- ifid_flush  out  1  IF/ID loads NOP; has priority over ifid_hold.
- idex_bubble  out  1  ID/EX loads NOP.
- issue  out  1  ID instruction advances to EX this cycle.
- redirect_err  out  1  sticky: pc_update seen outside a branch window.
- stall_cnt  out  CNT_W  saturating count of data-hazard stall cycles.

Behaviour:
- Reset (rst=0 at posedge):
  - FSM goes to RUN; scoreboard valids cleared; br_cnt=0; stall_cnt=0; redirect_err=0.
  - Combinational outputs evaluate with id_valid treated as 0 while rst=0, so all are 0.
  - Reset mid-branch-window abandons the window with no flush.
- Scoreboard:
  - Entries EX, MEM, WB, each {valid, rd}.
  - Shifts every cycle, never stalls: WB<-MEM, MEM<-EX, EX<-{issue & id_wr & (id_rd!=0), id_rd}.
- Hazard (combinational):
  - For each source: uses & reg!=0 & matches a valid entry.
  - Entries checked: EX and MEM, plus WB when WB_BYPASS=0.
  - Register 0 never hazards.
- RUN state:
  - id_valid=0: issue=0, idex_bubble=1, all other outputs 0.
  - id_valid & hazard: pc_hold=1, ifid_hold=1, idex_bubble=1, issue=0; stall_cnt+1, saturating at all-ones.
  - id_valid & no hazard: issue=1, other outputs 0.
  - Issue with id_is_branch=1:
    - Same cycle: pc_hold=1, ifid_flush=1, which drops the sequential fetch.
    - Next state BR_WAIT, br_cnt=BR_LAT.
- BR_WAIT state:
  - Every cycle: idex_bubble=1, issue=0; br_cnt decrements.
  - br_cnt>1: pc_hold=1, ifid_flush=1.
  - br_cnt==1 (branch in WB): pc_hold=0, so fetch loads pc_new on pc_update or fetches branch+4 otherwise.
    - ifid_flush=pc_update.
    - Next state RUN.
  - Data hazards are not evaluated in BR_WAIT; stall_cnt is not incremented.
- pc_update while in RUN (unexpected redirect):
  - ifid_flush=1, idex_bubble=1, issue=0.
  - EX and MEM scoreboard valids cleared at the edge.
  - redirect_err set; it clears only on reset.
- pc_update in BR_WAIT with br_cnt>1: ignored (outputs already flushing); redirect_err set.
- Latency: a hazard stall releases the cycle after the last matching entry shifts past the checked window.
  - Back-to-back dependent pair with WB_BYPASS=0: 3 stall cycles.
  - Back-to-back dependent pair with WB_BYPASS=1: 2 stall cycles.
- Priority: reset > pc_update redirect > BR_WAIT sequencing > data hazard > issue.

Decomposition:
- Package cpu_ctrl_pkg:
  - FSM state encoding (RUN, BR_WAIT).
  - REG_ZERO=5'd0.
  - Scoreboard entry struct {valid, rd[4:0]}.
  - NOP encoding 32'h0.
- Sub-module hazard_scoreboard:
  - Holds the 3-entry shift register, the clear-EX/MEM input, and the two comparator trees.
  - Output is a single hazard bit; WB_BYPASS is passed down.
  - Top level holds the FSM, br_cnt, stall_cnt and output decode.

Test Plan:
- Reset: hold rst=0 for 2 cycles with id_valid=1 -> all outputs 0, stall_cnt=0; first cycle after release with independent op -> issue=1.
- RAW stall: issue add rd=5, next op uses_rs rs=5 (WB_BYPASS=0) -> 3 cycles of pc_hold=ifid_hold=idex_bubble=1, issue on 4th cycle, stall_cnt=3; with WB_BYPASS=1 -> 2 cycles, stall_cnt=2.
- Register 0: issue op rd=0 with id_wr=1, next op rs=0 -> no stall, issue=1 both cycles.
- Taken branch: branch issued at cycle T; pc_update=1 at T+3 -> ifid_flush=1 at T..T+3, pc_hold=1 at T..T+2 and 0 at T+3, issue=1 allowed at T+4.
- Not-taken branch: as above with pc_update=0 -> ifid_flush=0 at T+3, IF/ID captures branch+4, RUN at T+4.
- Unexpected redirect: pc_update=1 in RUN with a pending rd=7 entry in EX -> ifid_flush=idex_bubble=1, redirect_err=1, following rs=7 consumer issues without stall.
